seq_etm_mult_ctrl: RTL and testbench

SEQ_ETM_MULT_CTRL -- requirements
Module: seq_etm_mult_ctrl

---
 rtl/seq_etm_mult_ctrl.sv | 106 ++++++++++
 tb/tb_seq_etm_mult_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_etm_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier with an optional truncated mode
// that skips the TRUNC low multiplier bits. IDLE -> RUN (one bit per cycle) -> DONE.
module seq_etm_mult_ctrl #(
  parameter int W     = 8,
  parameter int TRUNC = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod,
  output logic           busy
);

  localparam int IW = $clog2(W + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(W - 1);
  localparam logic [IW-1:0] TRUNC_IDX = IW'(TRUNC);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplier;

  // Explicit bit-serial carry chain; the final carry is dropped because the
  // product of two W-bit operands always fits in 2W bits.
  function automatic logic [2*W-1:0] rc_add(input logic [2*W-1:0] x,
                                            input logic [2*W-1:0] y);
    logic [2*W-1:0] s;
    logic           c;
    s = '0;
    c = 1'b0;
    for (int k = 0; k < 2*W; k++) begin
      s[k] = x[k] ^ y[k] ^ c;
      c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
    end
    return s;
  endfunction

  assign prod = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Operands are pre-aligned to the starting bit index so RUN only shifts.
            if (approx) begin
              mcand  <= {{W{1'b0}}, a} << TRUNC;
              mplier <= b >> TRUNC;
              idx    <= TRUNC_IDX;
            end else begin
              mcand  <= {{W{1'b0}}, a};
              mplier <= b;
              idx    <= '0;
            end
            acc      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (mplier[0])
            acc <= rc_add(acc, mcand);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          idx    <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_etm_mult_ctrl.sv
// Directed bench for seq_etm_mult_ctrl (W=8, TRUNC=4) with a random back-to-back tail.
module tb_seq_etm_mult_ctrl;

  localparam int W     = 8;
  localparam int TRUNC = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           approx;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] prod;
  logic           busy;

  int checks = 0;
  int errors = 0;

  seq_etm_mult_ctrl #(.W(W), .TRUNC(TRUNC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx(approx), .out_valid(out_valid),
    .out_ready(out_ready), .prod(prod), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic map);
    logic [W-1:0] bm;
    bm = map ? ((mb >> TRUNC) << TRUNC) : mb;
    return 32'(ma) * 32'(bm);
  endfunction

  // Accept one operation, scramble inputs, wait n RUN cycles, check DONE entry.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tap,
                        input int n, input logic [31:0] exp_p, input string tag);
    logic seen;
    a = ta; b = tb2; approx = tap; in_valid = 1'b1;
    step();
    chk({tag, "_busy"}, 32'(busy), 1);
    in_valid = 1'b0; a = ~ta; b = ~tb2; approx = ~tap;
    seen = 1'b0;
    for (int i = 1; i < n; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk({tag, "_early"}, 32'(seen), 0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_prod"}, 32'(prod), exp_p);
  endtask

  initial begin
    logic       seen;
    logic       pending, prev_ov, nxt_ap, acc_now, hs_now;
    logic [31:0] pend_exp;
    int         pend_n, pend_cyc, hs_cyc, n_acc, n_done;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; approx = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_prod", 32'(prod), 0);
    rst = 1'b0;

    // Exact 255*255, out_ready high: DONE lasts one cycle
    run_op(8'd255, 8'd255, 1'b0, 8, 65025, "exact_max");
    step();
    chk("exact_max_idle", 32'(in_ready), 1);
    chk("exact_max_ov_drop", 32'(out_valid), 0);

    run_op(8'd255, 8'd255, 1'b1, 4, 61200, "approx_max");
    step();
    chk("approx_max_idle", 32'(in_ready), 1);

    run_op(8'd0, 8'd77, 1'b0, 8, 0, "a_zero");
    step();
    run_op(8'd9, 8'd15, 1'b1, 4, 0, "approx_lowbits");
    step();
    run_op(8'd3, 8'd31, 1'b1, 4, 48, "approx_mixed");
    step();
    run_op(8'd200, 8'd0, 1'b0, 8, 0, "b_zero");
    step();

    // Backpressure in DONE with new operands offered
    out_ready = 1'b0;
    run_op(8'd13, 8'd11, 1'b0, 8, 143, "bp");
    in_valid = 1'b1; a = 8'd200; b = 8'd3; approx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_prod", 32'(prod), 143);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_release_idle", 32'(in_ready), 1);
    chk("bp_release_busy", 32'(busy), 0);
    chk("bp_release_ov", 32'(out_valid), 0);

    // Reset beats acceptance
    rst = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd5;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_prio_in_ready", 32'(in_ready), 1);
    chk("rst_prio_busy", 32'(busy), 0);

    // Reset on the third RUN cycle aborts the operation
    a = 8'd100; b = 8'd100; approx = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_prod", 32'(prod), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 0);
    run_op(8'd7, 8'd9, 1'b0, 8, 63, "after_abort");
    step();
    chk("after_abort_idle", 32'(in_ready), 1);

    // Back-to-back random stream, alternating modes, random consumer
    pending = 1'b0; prev_ov = 1'b0; nxt_ap = 1'b0;
    pend_exp = '0; pend_n = 0; pend_cyc = 0; hs_cyc = -1; n_acc = 0; n_done = 0;
    for (int c = 0; c < 2000; c++) begin
      a = W'($urandom); b = W'($urandom); approx = nxt_ap;
      in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1));
      acc_now = in_ready;
      hs_now  = out_valid && out_ready;
      prev_ov = out_valid;
      if (hs_now) begin
        chk("b2b_has_pending", 32'(pending), 1);
        chk("b2b_prod", 32'(prod), pend_exp);
        pending = 1'b0; n_done++; hs_cyc = c;
      end
      if (acc_now) begin
        if (hs_cyc >= 0) chk("b2b_throughput", 32'(c - hs_cyc), 1);
        chk("b2b_no_overlap", 32'(pending), 0);
        pend_exp = model(a, b, approx);
        pend_n   = approx ? (W - TRUNC) : W;
        pend_cyc = c; pending = 1'b1; n_acc++;
        nxt_ap = ~nxt_ap;
      end
      step();
      if (out_valid && !prev_ov)
        chk("b2b_latency", 32'(c - pend_cyc), 32'(pend_n));
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(n_acc - n_done), 32'(pending));
    chk("b2b_progress", 32'(n_acc > 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
